key_entry_buffer: RTL

//   Parametrised keypad key-entry controller: captures DEPTH symbols of DATA_W bits into
//   a buffer, tracks a saturating write index, supports backspace, confirm and clear.

---
 rtl/key_entry_pkg.sv | 17 +
 rtl/key_edge_detect.sv | 57 +++++
 rtl/key_entry_buffer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/key_entry_pkg.sv
// Shared types and constants for the keypad key-entry controller.
// The state encoding and index-width helper are used by the top and the edge detector.
package key_entry_pkg;

   typedef enum logic {
      ENTRY = 1'b0,
      DONE  = 1'b1
   } entry_state_e;

   // keyPress is active-low, so the idle level of the strobe and its history flops is 1.
   localparam logic KEY_IDLE_LEVEL = 1'b1;

   function automatic int idx_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Turns the active-low keyPress strobe into a one-cycle falling-edge pulse.
// With KEY_ENTRY_SYNC_EN defined, a 2-flop synchroniser sits ahead of the detector.
module key_edge_detect
   import key_entry_pkg::*;
(
   input  logic clock,
   input  logic reset,
   input  logic key_n,
   output logic fall_pulse
);

   logic kp_in;
   logic kp_q;
   logic kp_d;

`ifdef KEY_ENTRY_SYNC_EN
   logic sync1_q;
   logic sync1_d;
   logic sync2_q;
   logic sync2_d;

   always_comb begin
      sync1_d = key_n;
      sync2_d = sync1_q;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1_q <= KEY_IDLE_LEVEL;
         sync2_q <= KEY_IDLE_LEVEL;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

   assign kp_in = sync2_q;
`else
   assign kp_in = key_n;
`endif

   always_comb begin
      kp_d = kp_in;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         kp_q <= KEY_IDLE_LEVEL;
      end else begin
         kp_q <= kp_d;
      end
   end

   // A key held low produces exactly one pulse: kp_q follows the input the next edge.
   assign fall_pulse = kp_q & ~kp_in;

endmodule

// File: rtl/key_entry_buffer.sv
// Keypad key-entry buffer: DEPTH symbols, saturating index, backspace, confirm, clear.
// Optional keyPress synchroniser is enabled with the KEY_ENTRY_SYNC_EN macro.
//
//   state | meaning
//   ENTRY | accepting key events into the buffer
//   DONE  | key locked, keyValid high, events ignored until clear/reset
module key_entry_buffer
   import key_entry_pkg::*;
#(
   parameter  int DEPTH  = 16,
   parameter  int DATA_W = 4,
   localparam int IDX_W  = idx_width(DEPTH)
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      enterToKey,
   input  logic                      keyPress,
   input  logic                      backspace,
   input  logic [DATA_W-1:0]         keyData,
   input  logic                      confirm,
   input  logic                      clear,
   output logic [IDX_W-1:0]          index,
   output logic [DEPTH*DATA_W-1:0]   keyOut,
   output logic                      empty,
   output logic                      full,
   output logic                      overrun,
   output logic                      keyValid
);

   localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH);
   localparam logic [IDX_W-1:0] ONE_IDX   = IDX_W'(1);

   entry_state_e      state_q;
   entry_state_e      state_d;
   logic [IDX_W-1:0]  index_q;
   logic [IDX_W-1:0]  index_d;
   logic [DATA_W-1:0] slot_q [DEPTH];
   logic [DATA_W-1:0] slot_d [DEPTH];
   logic              overrun_q;
   logic              overrun_d;

   logic              key_event;
   logic              accept;
   logic              full_w;
   logic              empty_w;

   key_edge_detect u_edge (
      .clock      (clock),
      .reset      (reset),
      .key_n      (keyPress),
      .fall_pulse (key_event)
   );

   assign full_w  = (index_q == DEPTH_IDX);
   assign empty_w = (index_q == '0);
   assign accept  = key_event & enterToKey & (state_q == ENTRY);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ENTRY;
      end else begin
         state_q <= state_d;
      end
   end

   // A key event in the same cycle outranks confirm, so the lock waits a cycle.
   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = ENTRY;
      end else if ((state_q == ENTRY) && confirm && full_w && !accept) begin
         state_d = DONE;
      end
   end

   always_comb begin
      keyValid = (state_q == DONE);
   end

   always_comb begin
      index_d   = index_q;
      slot_d    = slot_q;
      overrun_d = 1'b0;
      if (clear) begin
         index_d = '0;
         for (int i = 0; i < DEPTH; i++) begin
            slot_d[i] = '0;
         end
      end else if (accept) begin
         if (!backspace) begin
            if (full_w) begin
               overrun_d = 1'b1;
            end else begin
               for (int i = 0; i < DEPTH; i++) begin
                  if (IDX_W'(i) == index_q) begin
                     slot_d[i] = keyData;
                  end
               end
               index_d = index_q + ONE_IDX;
            end
         end else if (!empty_w) begin
            // Backspace zeroes the vacated slot so keyOut never shows stale symbols.
            for (int i = 0; i < DEPTH; i++) begin
               if (IDX_W'(i) == (index_q - ONE_IDX)) begin
                  slot_d[i] = '0;
               end
            end
            index_d = index_q - ONE_IDX;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         index_q   <= '0;
         overrun_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            slot_q[i] <= '0;
         end
      end else begin
         index_q   <= index_d;
         overrun_q <= overrun_d;
         for (int i = 0; i < DEPTH; i++) begin
            slot_q[i] <= slot_d[i];
         end
      end
   end

   always_comb begin
      keyOut = '0;
      for (int i = 0; i < DEPTH; i++) begin
         keyOut[i*DATA_W +: DATA_W] = slot_q[i];
      end
   end

   assign index   = index_q;
   assign empty   = empty_w;
   assign full    = full_w;
   assign overrun = overrun_q;

endmodule
